draw_engine: RTL and testbench
==============================

// Module: draw_engine
// PURPOSE
//  Parametrised pixel-drawing engine feeding vga_adapter plot port; one engine replaces separate fill/circle units.
//  Modes: full-screen fill, axis-aligned rectangle fill, midpoint circle outline; one pixel per clock, off-screen
//  pixels clipped (plot suppressed). Sits between top-level sequencing FSM and vga_adapter, start/done handshake.
// PARAMETERS
//  SCREEN_W  160  visible columns; X_W = $clog2(SCREEN_W)
//  SCREEN_H  120  visible rows;    Y_W = $clog2(SCREEN_H)
//  COLOUR_W  3    colour bits per pixel
// PORTS
//  clk         in   1         clock, all state rises on posedge
//  rst         in   1         asynchronous, active-high reset
//  start       in   1         request; held high until done seen
//  mode        in   2         draw_pkg::mode_t: 00 FILL, 01 RECT, 10 CIRCLE, 11 reserved
//  colour      in   COLOUR_W  pixel colour
//  x0          in   X_W       RECT left column / CIRCLE centre x
//  y0          in   Y_W       RECT top row / CIRCLE centre y
//  w_or_r      in   X_W       RECT width / CIRCLE radius
//  h           in   Y_W       RECT height (ignored otherwise)
//  busy        out  1         high in RUN
//  done        out  1         high in DONE
//  vga_x       out  X_W       pixel column
//  vga_y       out  Y_W       pixel row
//  vga_colour  out  COLOUR_W  pixel colour
//  vga_plot    out  1         write strobe, only for on-screen pixels
// BEHAVIOUR
//  - Reset (async, any state): IDLE; busy, done, vga_plot = 0; vga_x, vga_y, vga_colour = 0.
//  - States IDLE -> RUN -> DONE -> IDLE. All outputs registered.
//  - IDLE: start=1 latches mode, colour, x0, y0, w_or_r, h; RUN next cycle. First pixel one cycle after latch.
//  - Inputs changing during RUN/DONE ignored (latched copies used).
//  - RUN, start dropped: abort; IDLE next cycle, vga_plot=0, done never pulses.
//  - FILL: column-major, x outer 0..SCREEN_W-1, y inner 0..SCREEN_H-1; SCREEN_W*SCREEN_H plot cycles.
//  - RECT: column-major over x0..x0+w-1, y0..y0+h-1; w*h cycles; w=0 or h=0 -> zero pixels, DONE after 1 RUN cycle.
//    Coordinates computed at X_W+1 / Y_W+1 bits; no wrap, pixels >= SCREEN_W/H clipped but still take a cycle.
//  - CIRCLE (midpoint): ox=r, oy=0, crit=1-r, signed X_W+3 bits. Per step 8 cycles, octant order
//    (cx+ox,cy+oy),(cx+oy,cy+ox),(cx-ox,cy+oy),(cx-oy,cy+ox),(cx-ox,cy-oy),(cx-oy,cy-ox),(cx+ox,cy-oy),(cx+oy,cy-ox);
//    then oy++; crit<=0 ? crit+=2*oy+1 : (ox--, crit+=2*(oy-ox)+1). Loop while oy<=ox.
//    Negative/overflow coords (signed X_W+2 / Y_W+2 math) clipped; cycle still spent. r=0: 8 cycles at centre.
//  - Mode 11: RUN one cycle, no plot, then DONE.
//  - After last pixel cycle: DONE; vga_plot=0. done stays high while start=1; start=0 -> IDLE next cycle.
//  - start high in DONE never retriggers; new job needs start low >= 1 cycle.
// STRUCTURE
//  - draw_pkg: mode_t enum, state_t enum {IDLE,RUN,DONE}, localparam octant count 8.
//  - Sub-module circle_octant: comb; (cx,cy,ox,oy,oct[2:0]) -> (px,py,on_screen); shared by RECT clip test.
// TESTING
//  1 FILL colour=3'b101: exactly 19200 plots, 1st (0,0) 2nd (0,1), last (159,119); done 1 cycle after.
//  2 RECT x0=10,y0=20,w=3,h=2: plots (10,20),(10,21),(11,20),(11,21),(12,20),(12,21); then done.
//  3 CIRCLE cx=80,cy=60,r=40: pixel set equals golden midpoint model; includes (120,60),(80,100),(40,60),(80,20).
//  4 CIRCLE cx=2,cy=2,r=10: no plot with x>=160 or y>=120; cycle count equals unclipped run.
//  5 Abort: drop start 50 cycles into FILL -> plot=0 next cycle, IDLE, done never high; restart completes.
//  6 rst mid-CIRCLE -> outputs zero same cycle (async); RECT w=0 -> done, zero plots.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the pixel-drawing engine.
package draw_pkg;

    typedef enum logic [1:0] {
        MODE_FILL   = 2'b00,
        MODE_RECT   = 2'b01,
        MODE_CIRCLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int unsigned OCT_N = 8;
    localparam int unsigned OCT_W = $clog2(OCT_N);

endpackage

// File: rtl/circle_octant.sv
// Maps a centre plus (ox,oy) offset and octant index to a pixel and an on-screen flag.
module circle_octant
    import draw_pkg::*;
#(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = $clog2(SCREEN_W),
    parameter int unsigned Y_W      = $clog2(SCREEN_H),
    parameter int unsigned C_W      = X_W + 3
) (
    input  logic [X_W-1:0]          cx_i,
    input  logic [Y_W-1:0]          cy_i,
    input  logic signed [C_W-1:0]   ox_i,
    input  logic signed [C_W-1:0]   oy_i,
    input  logic [OCT_W-1:0]        oct_i,
    output logic [X_W-1:0]          px_o,
    output logic [Y_W-1:0]          py_o,
    output logic                    on_screen_o
);

    logic signed [C_W-1:0] dx, dy, ax, ay;

    always_comb begin
        dx = ox_i;
        dy = oy_i;
        case (oct_i)
            3'd0:    begin dx =  ox_i; dy =  oy_i; end
            3'd1:    begin dx =  oy_i; dy =  ox_i; end
            3'd2:    begin dx = -ox_i; dy =  oy_i; end
            3'd3:    begin dx = -oy_i; dy =  ox_i; end
            3'd4:    begin dx = -ox_i; dy = -oy_i; end
            3'd5:    begin dx = -oy_i; dy = -ox_i; end
            3'd6:    begin dx =  ox_i; dy = -oy_i; end
            default: begin dx =  oy_i; dy = -ox_i; end
        endcase
        ax = $signed(C_W'(cx_i)) + dx;
        ay = $signed(C_W'(cy_i)) + dy;
        // wide enough that neither sum can wrap, so sign + bound test is exact
        on_screen_o = !ax[C_W-1] && !ay[C_W-1]
                   && (ax < $signed(C_W'(SCREEN_W)))
                   && (ay < $signed(C_W'(SCREEN_H)));
        px_o = ax[X_W-1:0];
        py_o = ay[Y_W-1:0];
    end

endmodule

// File: rtl/draw_engine.sv
// Fill / rectangle / midpoint-circle pixel generator feeding the VGA plot port, one pixel per clock.
module draw_engine
    import draw_pkg::*;
#(
    parameter  int unsigned SCREEN_W = 160,
    parameter  int unsigned SCREEN_H = 120,
    parameter  int unsigned COLOUR_W = 3,
    localparam int unsigned X_W      = $clog2(SCREEN_W),
    localparam int unsigned Y_W      = $clog2(SCREEN_H)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w_or_r,
    input  logic [Y_W-1:0]      h,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned C_W = ((X_W > Y_W) ? X_W : Y_W) + 3;

    state_t                state_q, state_d;
    logic                  load, step;
    mode_t                 mode_in;
    mode_t                 mode_q, mode_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic [X_W-1:0]        x0_q, x0_d, wlast_q, wlast_d, ix_q, ix_d;
    logic [Y_W-1:0]        y0_q, y0_d, hlast_q, hlast_d, iy_q, iy_d;
    logic                  empty_q, empty_d, last_q, last_d;
    logic signed [C_W-1:0] ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
    logic signed [C_W-1:0] ox_nx, oy_nx;
    logic [OCT_W-1:0]      oct_q, oct_d;

    logic signed [C_W-1:0] gen_ox, gen_oy;
    logic [OCT_W-1:0]      gen_oct;
    logic [X_W-1:0]        px;
    logic [Y_W-1:0]        py;
    logic                  on_screen;

    logic                  busy_q, busy_d, done_q, done_d, plot_q, plot_d;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;

    assign mode_in = mode_t'(mode);

    // Sequencing: load on request, step through pixels, finish after the last one.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!start)      state_d = ST_IDLE;
                else if (last_q) state_d = ST_DONE;
                else             step    = 1'b1;
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Job latch and pixel walker; *_d always describes the pixel shown next cycle.
    always_comb begin
        mode_d   = mode_q;
        colour_d = colour_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        wlast_d  = wlast_q;
        hlast_d  = hlast_q;
        empty_d  = empty_q;
        ix_d     = ix_q;
        iy_d     = iy_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        oct_d    = oct_q;
        last_d   = last_q;

        if (load) begin
            mode_d   = mode_in;
            colour_d = colour;
            x0_d     = x0;
            y0_d     = y0;
            wlast_d  = w_or_r - X_W'(1);
            hlast_d  = h - Y_W'(1);
            empty_d  = 1'b0;
            case (mode_in)
                MODE_FILL: begin
                    x0_d    = '0;
                    y0_d    = '0;
                    wlast_d = X_W'(SCREEN_W - 1);
                    hlast_d = Y_W'(SCREEN_H - 1);
                end
                MODE_RECT:   empty_d = (w_or_r == '0) || (h == '0);
                MODE_CIRCLE: empty_d = 1'b0;
                default:     empty_d = 1'b1;
            endcase
            ix_d   = '0;
            iy_d   = '0;
            oct_d  = '0;
            ox_d   = $signed(C_W'(w_or_r));
            oy_d   = '0;
            crit_d = C_W'(1) - $signed(C_W'(w_or_r));
        end else if (step) begin
            if (mode_q == MODE_CIRCLE) begin
                oct_d = oct_q + OCT_W'(1);
                if (oct_q == OCT_W'(OCT_N - 1)) begin
                    oy_d = oy_q + C_W'(1);
                    if (crit_q[C_W-1] || (crit_q == '0)) begin
                        crit_d = crit_q + (oy_d <<< 1) + C_W'(1);
                    end else begin
                        ox_d   = ox_q - C_W'(1);
                        crit_d = crit_q + ((oy_d - ox_d) <<< 1) + C_W'(1);
                    end
                end
            end else if (iy_q == hlast_q) begin
                iy_d = '0;
                ix_d = ix_q + X_W'(1);
            end else begin
                iy_d = iy_q + Y_W'(1);
            end
        end

        // Circle ends on the last octant of a step whose successor would break oy <= ox.
        oy_nx = oy_d + C_W'(1);
        ox_nx = (crit_d[C_W-1] || (crit_d == '0)) ? ox_d : ox_d - C_W'(1);
        if (load || step) begin
            if (mode_d == MODE_CIRCLE)
                last_d = (oct_d == OCT_W'(OCT_N - 1)) && (oy_nx > ox_nx);
            else
                last_d = empty_d || ((ix_d == wlast_d) && (iy_d == hlast_d));
        end
    end

    // Rectangle and fill reuse octant 0 (cx+ox, cy+oy) for their clip test.
    always_comb begin
        gen_ox  = $signed(C_W'(ix_d));
        gen_oy  = $signed(C_W'(iy_d));
        gen_oct = '0;
        if (mode_d == MODE_CIRCLE) begin
            gen_ox  = ox_d;
            gen_oy  = oy_d;
            gen_oct = oct_d;
        end
    end

    circle_octant #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .C_W      (C_W)
    ) u_octant (
        .cx_i        (x0_d),
        .cy_i        (y0_d),
        .ox_i        (gen_ox),
        .oy_i        (gen_oy),
        .oct_i       (gen_oct),
        .px_o        (px),
        .py_o        (py),
        .on_screen_o (on_screen)
    );

    always_comb begin
        busy_d       = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if ((load || step) && !empty_d && on_screen) begin
            plot_d       = 1'b1;
            vga_x_d      = px;
            vga_y_d      = py;
            vga_colour_d = colour_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_FILL;
            colour_q     <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            wlast_q      <= '0;
            hlast_q      <= '0;
            empty_q      <= 1'b0;
            last_q       <= 1'b0;
            ix_q         <= '0;
            iy_q         <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            oct_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            colour_q     <= colour_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            wlast_q      <= wlast_d;
            hlast_q      <= hlast_d;
            empty_q      <= empty_d;
            last_q       <= last_d;
            ix_q         <= ix_d;
            iy_q         <= iy_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            oct_q        <= oct_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: expected pixels queued per job, popped as the engine plots them.
module tb_draw_engine;

    logic       clk, rst, start;
    logic [1:0] mode;
    logic [2:0] colour;
    logic [7:0] x0, w_or_r;
    logic [6:0] y0, h;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          plots, oob, done_hits, circ_cyc;
    logic [3:0]  hits;

    draw_engine #(.SCREEN_W(160), .SCREEN_H(120), .COLOUR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .colour     (colour),
        .x0         (x0),
        .y0         (y0),
        .w_or_r     (w_or_r),
        .h          (h),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input int x, input int y, input int c);
        return 32'((x << 11) | (y << 3) | c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_rect(input int ax, input int ay, input int aw, input int ah, input int c);
        for (int i = 0; i < aw; i++)
            for (int j = 0; j < ah; j++)
                if (ax + i < 160 && ay + j < 120) exp_q.push_back(pk(ax + i, ay + j, c));
    endtask

    task automatic push_circle(input int cx, input int cy, input int r, input int c, output int cyc);
        int ox, oy, crit, px, py;
        ox = r; oy = 0; crit = 1 - r; cyc = 0;
        while (oy <= ox) begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - ox; py = cy + oy; end
                    3: begin px = cx - oy; py = cy + ox; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + ox; py = cy - oy; end
                    default: begin px = cx + oy; py = cy - ox; end
                endcase
                cyc++;
                if (px >= 0 && px < 160 && py >= 0 && py < 120) exp_q.push_back(pk(px, py, c));
            end
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endtask

    task automatic run_job(input logic [1:0] m, input logic [2:0] c, input int ax, input int ay,
                           input int aw, input int ah, input int exp_cyc, input bit tail,
                           input string tag);
        int runc, cyc, last_plot, done_cyc;
        bit seen;
        @(negedge clk);
        mode = m; colour = c; x0 = 8'(ax); y0 = 7'(ay); w_or_r = 8'(aw); h = 7'(ah);
        start = 1'b1;
        @(posedge clk);
        #1;
        mode = 2'($urandom); colour = 3'($urandom); x0 = 8'($urandom); y0 = 7'($urandom);
        w_or_r = 8'($urandom); h = 7'($urandom);
        runc = 0; cyc = 0; seen = 1'b0; last_plot = -1; done_cyc = -1;
        while (!seen && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                chk({tag, " plot_in_done"}, 32'(vga_plot), 32'd0);
            end else begin
                if (busy) runc++;
                if (vga_plot) begin
                    plots++;
                    last_plot = cyc;
                    if (vga_x >= 160 || vga_y >= 120) oob++;
                    if (vga_x == 120 && vga_y == 60)  hits[0] = 1'b1;
                    if (vga_x == 80  && vga_y == 100) hits[1] = 1'b1;
                    if (vga_x == 40  && vga_y == 60)  hits[2] = 1'b1;
                    if (vga_x == 80  && vga_y == 20)  hits[3] = 1'b1;
                    if (exp_q.size() == 0)
                        chk({tag, " extra_plot"}, pk(vga_x, vga_y, vga_colour), 32'hFFFF_FFFF);
                    else
                        chk({tag, " pixel"}, pk(vga_x, vga_y, vga_colour), exp_q.pop_front());
                end
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " run_cycles"}, 32'(runc), 32'(exp_cyc));
        chk({tag, " missing_pixels"}, 32'(exp_q.size()), 32'd0);
        if (tail) chk({tag, " done_lag"}, 32'(done_cyc - last_plot), 32'd1);
        exp_q.delete();
        @(negedge clk);
        chk({tag, " done_held"}, 32'(done), 32'd1);
        chk({tag, " no_retrigger"}, 32'(busy), 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " idle_done"}, 32'(done), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"},   32'(busy),       32'd0);
        chk({tag, " done"},   32'(done),       32'd0);
        chk({tag, " plot"},   32'(vga_plot),   32'd0);
        chk({tag, " x"},      32'(vga_x),      32'd0);
        chk({tag, " y"},      32'(vga_y),      32'd0);
        chk({tag, " colour"}, 32'(vga_colour), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = '0; colour = '0;
        x0 = '0; y0 = '0; w_or_r = '0; h = '0;
        plots = 0; oob = 0; hits = '0; done_hits = 0; circ_cyc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // full-screen fill, geometry inputs must be ignored
        plots = 0;
        push_rect(0, 0, 160, 120, 5);
        run_job(2'b00, 3'b101, 33, 44, 7, 9, 19200, 1'b1, "fill");
        chk("fill plot_count", 32'(plots), 32'd19200);

        push_rect(10, 20, 3, 2, 3);
        run_job(2'b01, 3'd3, 10, 20, 3, 2, 6, 1'b1, "rect");

        // rectangle straddling the bottom-right corner
        push_rect(158, 118, 4, 3, 6);
        run_job(2'b01, 3'd6, 158, 118, 4, 3, 12, 1'b0, "rect_clip");

        hits = '0;
        push_circle(80, 60, 40, 2, circ_cyc);
        run_job(2'b10, 3'd2, 80, 60, 40, 0, circ_cyc, 1'b0, "circle");
        chk("circle axis_points", 32'(hits), 32'hF);

        oob = 0;
        push_circle(2, 2, 10, 7, circ_cyc);
        run_job(2'b10, 3'd7, 2, 2, 10, 0, circ_cyc, 1'b0, "circle_clip");
        chk("circle_clip off_screen", 32'(oob), 32'd0);

        push_circle(50, 50, 0, 1, circ_cyc);
        run_job(2'b10, 3'd1, 50, 50, 0, 0, circ_cyc, 1'b0, "circle_r0");
        chk("circle_r0 model_cycles", 32'(circ_cyc), 32'd8);

        // abort a fill 50 cycles in
        @(negedge clk);
        mode = 2'b00; colour = 3'd4; start = 1'b1;
        @(posedge clk);
        plots = 0; done_hits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (vga_plot) plots++;
            if (done) done_hits++;
        end
        start = 1'b0;
        @(negedge clk);
        chk("abort plot", 32'(vga_plot), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort plots_before", 32'(plots), 32'd50);
        repeat (3) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        chk("abort done_never", 32'(done_hits), 32'd0);
        push_rect(0, 0, 160, 120, 4);
        run_job(2'b00, 3'd4, 0, 0, 0, 0, 19200, 1'b1, "refill");

        // asynchronous reset mid-circle
        @(negedge clk);
        mode = 2'b10; colour = 3'd7; x0 = 8'd80; y0 = 7'd60; w_or_r = 8'd40; start = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst busy", 32'(busy), 32'd0);

        run_job(2'b01, 3'd6, 5, 5, 0, 4, 1, 1'b0, "rect_w0");
        run_job(2'b01, 3'd6, 5, 5, 4, 0, 1, 1'b0, "rect_h0");
        run_job(2'b11, 3'd5, 5, 5, 4, 4, 1, 1'b0, "reserved");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
